// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and width helper for the LED pattern generator.
package led_pattern_pkg;

  localparam logic [1:0] MODE_BINARY  = 2'd0;
  localparam logic [1:0] MODE_GRAY    = 2'd1;
  localparam logic [1:0] MODE_SCAN    = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  // Bits needed to hold v-1, never less than 1.
  function automatic int clog2(input longint unsigned v);
    longint unsigned x;
    int r;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-tick prescaler: counts 0..DIV-1, freezes under hold, emits a
// combinational advance strobe and a registered one-cycle tick.
module led_prescaler
  import led_pattern_pkg::*;
#(
  parameter longint unsigned DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic adv,
  output logic tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign adv = !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= adv;
      if (!hold) cnt <= adv ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step engine (binary, Gray, bouncing
// scanner, PWM breathing) feeding a registered LED bank.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned     NUM_LEDS = 8,
  parameter longint unsigned DIV      = 1_000_000,
  parameter int unsigned     PWM_W    = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [1:0]          MODE,
  input  logic                HOLD,
  output logic [NUM_LEDS-1:0] LED,
  output logic                TICK
);

  localparam int PW = clog2(NUM_LEDS);
  localparam logic [PW-1:0]    POS_LAST = PW'(NUM_LEDS - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  logic                adv;
  logic [1:0]          cur_mode;
  logic [NUM_LEDS-1:0] step;
  logic [PW-1:0]       pos;
  logic                scan_down;
  logic [PWM_W-1:0]    duty;
  logic                br_down;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [NUM_LEDS-1:0] decode;

  led_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (CLK),
    .rst_n (RST_N),
    .hold  (HOLD),
    .adv   (adv),
    .tick  (TICK)
  );

  // A mode change on a tick reinitialises the engine instead of advancing it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_mode  <= MODE_BINARY;
      step      <= '0;
      pos       <= '0;
      scan_down <= 1'b0;
      duty      <= '0;
      br_down   <= 1'b0;
    end else if (adv) begin
      if (MODE != cur_mode) begin
        cur_mode  <= MODE;
        step      <= '0;
        pos       <= '0;
        scan_down <= 1'b0;
        duty      <= '0;
        br_down   <= 1'b0;
      end else begin
        case (cur_mode)
          MODE_BINARY, MODE_GRAY: step <= step + NUM_LEDS'(1);
          MODE_SCAN: begin
            if (!scan_down) begin
              if (pos == POS_LAST) begin
                scan_down <= 1'b1;
                pos       <= pos - PW'(1);
              end else begin
                pos <= pos + PW'(1);
              end
            end else begin
              if (pos == '0) begin
                scan_down <= 1'b0;
                pos       <= PW'(1);
              end else begin
                pos <= pos - PW'(1);
              end
            end
          end
          default: begin
            // Ends are visited once: reverse and step away in the same tick.
            if (!br_down) begin
              if (duty == DUTY_MAX) begin
                br_down <= 1'b1;
                duty    <= duty - PWM_W'(1);
              end else begin
                duty <= duty + PWM_W'(1);
              end
            end else begin
              if (duty == '0) begin
                br_down <= 1'b0;
                duty    <= PWM_W'(1);
              end else begin
                duty <= duty - PWM_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // PWM runs every clock regardless of hold or mode.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  always_comb begin
    decode = '0;
    case (cur_mode)
      MODE_BINARY: decode = step;
      MODE_GRAY:   decode = step ^ (step >> 1);
      MODE_SCAN:   decode = NUM_LEDS'(1) << pos;
      default:     decode = {NUM_LEDS{pwm_cnt < duty}};
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) LED <= '0;
    else        LED <= decode;
  end

endmodule
